cpu_sequencer: RTL and testbench

- Multi-cycle control FSM for the CPU core.
- Sequences fetch, decode, execute and store phases around the combinational instruction decoder.
- Evaluates the ARM condition field against the CPSR flags and turns the decoder's level enables into single-cycle, phase-qualified strobes.
- Owns the memory request handshake, a wait-state timeout, halt control and a retired-instruction counter.

---
 rtl/cpu_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_cpu_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/decode/execute/store control FSM.
// Gates decoder enables by ARM condition codes and owns the memory handshake.
module cpu_sequencer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      fd_instruction,
  input  logic [3:0]       cpsr_flags,
  input  logic             de_reg_write_en,
  input  logic             de_reg_pc_write_en,
  input  logic             de_reg_cpsr_write_en,
  input  logic             de_mem_write_en,
  input  logic             de_data_out_en,
  input  logic             de_addreg_update,
  input  logic [1:0]       de_addreg_sel,
  input  logic             mem_ready,
  input  logic             halt_req,
  output logic             mem_req,
  output logic             mem_we,
  output logic             ir_load,
  output logic             reg_write_stb,
  output logic             pc_write_stb,
  output logic             cpsr_write_stb,
  output logic             data_out_stb,
  output logic             addreg_update_stb,
  output logic [1:0]       addreg_sel_out,
  output logic             cond_pass,
  output logic [2:0]       seq_state,
  output logic [CNT_W-1:0] retired_count,
  output logic             mem_fault,
  output logic             halted
);

  localparam logic [2:0] S_BOOT  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_DEC   = 3'd2;
  localparam logic [2:0] S_EXEC  = 3'd3;
  localparam logic [2:0] S_MEM   = 3'd4;
  localparam logic [2:0] S_HALT  = 3'd5;
  localparam logic [2:0] S_FAULT = 3'd6;

  localparam logic [7:0]       TMO     = 8'(MEM_TIMEOUT);
  localparam logic [7:0]       W_ONE   = 8'd1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [1:0]       SEL_INC = 2'b10;

  logic [2:0]       state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_q, fault_d;

  logic       f_n, f_z, f_c, f_v;
  logic       cond_ok;
  logic [7:0] wait_inc;
  logic       timeout;
  logic [2:0] done_state;
  logic       unused_ir;

  assign {f_n, f_z, f_c, f_v} = cpsr_flags;
  assign unused_ir = ^fd_instruction[27:0];

  assign wait_inc   = wait_q + W_ONE;
  assign timeout    = (wait_inc == TMO);
  assign done_state = halt_req ? S_HALT : S_FETCH;

  always_comb begin
    cond_ok = 1'b0;
    unique case (fd_instruction[31:28])
      4'h0: cond_ok = f_z;
      4'h1: cond_ok = !f_z;
      4'h2: cond_ok = f_c;
      4'h3: cond_ok = !f_c;
      4'h4: cond_ok = f_n;
      4'h5: cond_ok = !f_n;
      4'h6: cond_ok = f_v;
      4'h7: cond_ok = !f_v;
      4'h8: cond_ok = f_c && !f_z;
      4'h9: cond_ok = !f_c || f_z;
      4'hA: cond_ok = (f_n == f_v);
      4'hB: cond_ok = (f_n != f_v);
      4'hC: cond_ok = !f_z && (f_n == f_v);
      4'hD: cond_ok = f_z || (f_n != f_v);
      4'hE: cond_ok = 1'b1;
      4'hF: cond_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d           = state_q;
    wait_d            = '0;
    cnt_d             = cnt_q;
    fault_d           = fault_q;
    mem_req           = 1'b0;
    mem_we            = 1'b0;
    ir_load           = 1'b0;
    reg_write_stb     = 1'b0;
    pc_write_stb      = 1'b0;
    cpsr_write_stb    = 1'b0;
    data_out_stb      = 1'b0;
    addreg_update_stb = 1'b0;
    addreg_sel_out    = SEL_INC;
    cond_pass         = 1'b0;
    halted            = 1'b0;
    unique case (state_q)
      S_BOOT: state_d = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_load = 1'b1;
          state_d = S_DEC;
        end else if (timeout) begin
          state_d = S_FAULT;
          fault_d = 1'b1;
        end else begin
          wait_d = wait_inc;
        end
      end
      S_DEC: state_d = S_EXEC;
      S_EXEC: begin
        cond_pass = cond_ok;
        if (cond_ok) begin
          reg_write_stb     = de_reg_write_en;
          pc_write_stb      = de_reg_pc_write_en;
          addreg_update_stb = de_addreg_update;
          addreg_sel_out    = de_addreg_sel;
          if (de_mem_write_en) begin
            state_d = S_MEM;
          end else begin
            cpsr_write_stb = de_reg_cpsr_write_en;
            cnt_d          = cnt_q + CNT_ONE;
            state_d        = done_state;
          end
        end else begin
          // failed condition: fall through to the next sequential PC
          pc_write_stb      = 1'b1;
          addreg_update_stb = 1'b1;
          cnt_d             = cnt_q + CNT_ONE;
          state_d           = done_state;
        end
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_we       = 1'b1;
        data_out_stb = de_data_out_en;
        if (mem_ready) begin
          cnt_d   = cnt_q + CNT_ONE;
          state_d = done_state;
        end else if (timeout) begin
          state_d = S_FAULT;
          fault_d = 1'b1;
        end else begin
          wait_d = wait_inc;
        end
      end
      S_HALT: begin
        halted = 1'b1;
        if (!halt_req) state_d = S_FETCH;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_BOOT;
      wait_q  <= '0;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  assign seq_state     = state_q;
  assign retired_count = cnt_q;
  assign mem_fault     = fault_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed cycle vectors feed a scoreboard queue;
// a negedge monitor pops one expectation per cycle and compares.
module tb_cpu_sequencer;

  localparam logic [2:0] S_BOOT  = 3'd0;
  localparam logic [2:0] S_FE    = 3'd1;
  localparam logic [2:0] S_DE    = 3'd2;
  localparam logic [2:0] S_EX    = 3'd3;
  localparam logic [2:0] S_MEM   = 3'd4;
  localparam logic [2:0] S_HALT  = 3'd5;
  localparam logic [2:0] S_FAULT = 3'd6;

  // output vector bits:
  // {req,we,ir,rw,pw,cw,dout,upd,sel[1:0],cond,fault,halted}
  localparam logic [12:0] O_IDLE  = 13'h0010;
  localparam logic [12:0] O_HALT  = 13'h0011;
  localparam logic [12:0] O_FAULT = 13'h0012;
  localparam logic [12:0] O_FW    = 13'h1010;
  localparam logic [12:0] O_FL    = 13'h1410;
  localparam logic [12:0] O_MEMD  = 13'h1850;
  localparam logic [12:0] O_MEMN  = 13'h1810;
  localparam logic [12:0] O_FAIL  = 13'h0130;
  localparam logic [12:0] O_RWOK  = 13'h0204;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] fd_instruction = '0;
  logic [3:0]  cpsr_flags = '0;
  logic        de_reg_write_en = 1'b0;
  logic        de_reg_pc_write_en = 1'b0;
  logic        de_reg_cpsr_write_en = 1'b0;
  logic        de_mem_write_en = 1'b0;
  logic        de_data_out_en = 1'b0;
  logic        de_addreg_update = 1'b0;
  logic [1:0]  de_addreg_sel = '0;
  logic        mem_ready = 1'b0;
  logic        halt_req = 1'b0;
  logic        mem_req, mem_we, ir_load;
  logic        reg_write_stb, pc_write_stb, cpsr_write_stb;
  logic        data_out_stb, addreg_update_stb;
  logic [1:0]  addreg_sel_out;
  logic        cond_pass;
  logic [2:0]  seq_state;
  logic [31:0] retired_count;
  logic        mem_fault, halted;

  cpu_sequencer #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .fd_instruction(fd_instruction), .cpsr_flags(cpsr_flags),
    .de_reg_write_en(de_reg_write_en),
    .de_reg_pc_write_en(de_reg_pc_write_en),
    .de_reg_cpsr_write_en(de_reg_cpsr_write_en),
    .de_mem_write_en(de_mem_write_en),
    .de_data_out_en(de_data_out_en),
    .de_addreg_update(de_addreg_update),
    .de_addreg_sel(de_addreg_sel),
    .mem_ready(mem_ready), .halt_req(halt_req),
    .mem_req(mem_req), .mem_we(mem_we), .ir_load(ir_load),
    .reg_write_stb(reg_write_stb), .pc_write_stb(pc_write_stb),
    .cpsr_write_stb(cpsr_write_stb), .data_out_stb(data_out_stb),
    .addreg_update_stb(addreg_update_stb),
    .addreg_sel_out(addreg_sel_out), .cond_pass(cond_pass),
    .seq_state(seq_state), .retired_count(retired_count),
    .mem_fault(mem_fault), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [2:0]  st;
    logic [12:0] o;
    logic [31:0] c;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int checks = 0;
  int errors = 0;
  int ecnt = 0;

  logic [31:0] nx_ins = '0;
  logic [3:0]  nx_fl = '0;
  logic [5:0]  nx_de = '0;
  logic [1:0]  nx_sel = '0;

  logic [12:0] obs;
  assign obs = {mem_req, mem_we, ir_load, reg_write_stb, pc_write_stb,
                cpsr_write_stb, data_out_stb, addreg_update_stb,
                addreg_sel_out, cond_pass, mem_fault, halted};

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      me = sb.pop_front();
      checks++;
      if (seq_state !== me.st) begin
        errors++;
        $display("FAIL %s state: got %0d want %0d",
                 me.tag, seq_state, me.st);
      end
      checks++;
      if (obs !== me.o) begin
        errors++;
        $display("FAIL %s outputs: got %h want %h", me.tag, obs, me.o);
      end
      checks++;
      if (retired_count !== me.c) begin
        errors++;
        $display("FAIL %s retired: got %0d want %0d",
                 me.tag, retired_count, me.c);
      end
    end
  end

  // de vector: {rw, pw, cw, mw, dw, uw}
  task automatic set_de(input logic [31:0] ins, input logic [3:0] fl,
                        input logic [5:0] de, input logic [1:0] sel);
    nx_ins = ins;
    nx_fl  = fl;
    nx_de  = de;
    nx_sel = sel;
  endtask

  task automatic step(input string tag, input logic rst, input logic rdy,
                      input logic hlt, input logic [2:0] st,
                      input logic [12:0] o);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n          = rst;
    mem_ready      = rdy;
    halt_req       = hlt;
    fd_instruction = nx_ins;
    cpsr_flags     = nx_fl;
    {de_reg_write_en, de_reg_pc_write_en, de_reg_cpsr_write_en,
     de_mem_write_en, de_data_out_en, de_addreg_update} = nx_de;
    de_addreg_sel  = nx_sel;
    e.tag = tag;
    e.st  = st;
    e.o   = o;
    e.c   = 32'(ecnt);
    sb.push_back(e);
  endtask

  task automatic run_op(input string tag, input logic hlt,
                        input logic [12:0] xo);
    step(tag, 1'b1, 1'b1, 1'b0, S_FE, O_FL);
    step(tag, 1'b1, 1'b1, hlt, S_DE, O_IDLE);
    step(tag, 1'b1, 1'b1, hlt, S_EX, xo);
    ecnt++;
  endtask

  typedef struct {
    logic [3:0] cc;
    logic [3:0] fl;
    logic       pass;
  } cc_t;

  cc_t cct[19] = '{
    '{4'h0, 4'b0100, 1'b1}, '{4'h1, 4'b0100, 1'b0},
    '{4'h2, 4'b0010, 1'b1}, '{4'h3, 4'b0010, 1'b0},
    '{4'h4, 4'b1000, 1'b1}, '{4'h5, 4'b1000, 1'b0},
    '{4'h6, 4'b0001, 1'b1}, '{4'h7, 4'b0001, 1'b0},
    '{4'h8, 4'b0010, 1'b1}, '{4'h8, 4'b0110, 1'b0},
    '{4'h9, 4'b0110, 1'b1}, '{4'hA, 4'b1001, 1'b1},
    '{4'hB, 4'b1001, 1'b0}, '{4'hC, 4'b1001, 1'b1},
    '{4'hC, 4'b1101, 1'b0}, '{4'hD, 4'b0000, 1'b0},
    '{4'hD, 4'b1000, 1'b1}, '{4'hE, 4'b0000, 1'b1},
    '{4'hF, 4'b1111, 1'b0}
  };

  initial begin
    #1 rst_n = 1'b0;
    step("rst0", 1'b0, 1'b0, 1'b0, S_BOOT, O_IDLE);
    step("rst1", 1'b0, 1'b1, 1'b1, S_BOOT, O_IDLE);
    step("boot", 1'b1, 1'b0, 1'b0, S_BOOT, O_IDLE);

    set_de(32'hE0811002, 4'b0000, 6'b101001, 2'b01);
    step("add_f0", 1'b1, 1'b0, 1'b0, S_FE, O_FW);
    step("add_f1", 1'b1, 1'b1, 1'b0, S_FE, O_FL);
    step("add_de", 1'b1, 1'b1, 1'b0, S_DE, O_IDLE);
    step("add_ex", 1'b1, 1'b1, 1'b0, S_EX, 13'h02AC);
    ecnt++;

    set_de(32'h0A000004, 4'b0000, 6'b010001, 2'b00);
    run_op("beq_nz", 1'b0, O_FAIL);
    set_de(32'h0A000004, 4'b0100, 6'b010001, 2'b00);
    run_op("beq_z", 1'b0, 13'h0124);
    set_de(32'h10911002, 4'b0100, 6'b101000, 2'b01);
    run_op("addsne", 1'b0, O_FAIL);
    set_de(32'h15801000, 4'b0100, 6'b000110, 2'b00);
    run_op("strne", 1'b0, O_FAIL);

    for (int i = 0; i < 19; i++) begin
      set_de({cct[i].cc, 28'h0811002}, cct[i].fl, 6'b100000, 2'b00);
      run_op($sformatf("cc%0d", i), 1'b0, cct[i].pass ? O_RWOK : O_FAIL);
    end

    set_de(32'hE0811002, 4'b0000, 6'b100000, 2'b00);
    step("hlt_f", 1'b1, 1'b1, 1'b0, S_FE, O_FL);
    step("hlt_d", 1'b1, 1'b0, 1'b1, S_DE, O_IDLE);
    step("hlt_x", 1'b1, 1'b0, 1'b1, S_EX, O_RWOK);
    ecnt++;
    step("hlt_h0", 1'b1, 1'b1, 1'b1, S_HALT, O_HALT);
    step("hlt_h1", 1'b1, 1'b0, 1'b0, S_HALT, O_HALT);

    set_de(32'hE5801000, 4'b0000, 6'b001111, 2'b00);
    step("st_fw", 1'b1, 1'b0, 1'b0, S_FE, O_FW);
    for (int i = 0; i < 11; i++)
      step("st_fw", 1'b1, 1'b0, 1'b0, S_FE, O_FW);
    step("st_fl", 1'b1, 1'b1, 1'b0, S_FE, O_FL);
    step("st_de", 1'b1, 1'b0, 1'b0, S_DE, O_IDLE);
    step("st_ex", 1'b1, 1'b0, 1'b0, S_EX, 13'h0024);
    for (int i = 0; i < 3; i++)
      step("st_mw", 1'b1, 1'b0, 1'b0, S_MEM, O_MEMD);
    step("st_md", 1'b1, 1'b1, 1'b0, S_MEM, O_MEMD);
    ecnt++;

    set_de(32'hE5801000, 4'b0000, 6'b000101, 2'b00);
    for (int i = 0; i < 5; i++)
      step("st2_fw", 1'b1, 1'b0, 1'b0, S_FE, O_FW);
    step("st2_fl", 1'b1, 1'b1, 1'b0, S_FE, O_FL);
    step("st2_de", 1'b1, 1'b0, 1'b0, S_DE, O_IDLE);
    step("st2_ex", 1'b1, 1'b0, 1'b0, S_EX, 13'h0024);
    for (int i = 0; i < 15; i++)
      step("st2_mw", 1'b1, 1'b0, 1'b1, S_MEM, O_MEMN);
    step("st2_md", 1'b1, 1'b1, 1'b1, S_MEM, O_MEMN);
    ecnt++;
    step("st2_h0", 1'b1, 1'b0, 1'b1, S_HALT, O_HALT);
    step("st2_h1", 1'b1, 1'b0, 1'b0, S_HALT, O_HALT);

    set_de(32'hE5801000, 4'b0000, 6'b000111, 2'b00);
    run_op("st3", 1'b0, 13'h0024);
    ecnt--;
    step("st3_mw", 1'b1, 1'b0, 1'b0, S_MEM, O_MEMD);
    ecnt = 0;
    step("rst_mem", 1'b0, 1'b0, 1'b0, S_BOOT, O_IDLE);
    step("rst_rel", 1'b1, 1'b0, 1'b0, S_BOOT, O_IDLE);

    for (int i = 0; i < 16; i++)
      step("to_fw", 1'b1, 1'b0, 1'b0, S_FE, O_FW);
    for (int i = 0; i < 4; i++)
      step("fault", 1'b1, 1'b1, 1'b1, S_FAULT, O_FAULT);

    for (int i = 0; i < 10 && sb.size() > 0; i++)
      @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
